// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and constants for the 16-bit RISC pipeline
package risc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OUT   = 2'd2
    } fetch_state_t;

    // Opcode occupies the top OPCODE_W bits; the immediate flag sits just below it.
    localparam int OPCODE_W          = 5;
    localparam int OPCODE_LSB_OFFSET = 5;
    localparam int IMM_BIT_OFFSET    = 6;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    // Opcodes the control unit decodes; kept here so both stages agree.
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_B    = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_CALL = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_RET  = 5'b10100;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with redirect > increment > hold select
module fetch_pc_reg
    import risc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              PC_INC   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_inc;

    // Sequential increment wraps silently at the top of the address space.
    assign w_pc_inc = r_pc + PC_INC[PC_W-1:0];
    assign o_pc     = r_pc;

    // A redirect always wins; otherwise advance only when an instruction is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= w_pc_inc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the control unit
module fetch_unit
    import risc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              PC_INC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_W-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INST_W-1:0]   imem_rsp_data,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_W-1:0]   inst,
    output logic [PC_W-1:0]     inst_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic                imm
);

    fetch_state_t      r_state;
    logic              r_drop;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_inst_pc;
    logic              r_inst_valid;

    logic [PC_W-1:0]   w_pc;
    logic              w_req_fire;
    logic              w_rsp_take;

    // A redirect suppresses the request so the wrong-path address is never issued.
    assign imem_req_valid = rst_n && (r_state == FETCH) && !redirect;
    assign imem_req_addr  = w_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_take     = (r_state == WAIT) && imem_rsp_valid && !r_drop && !redirect;

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign opcode     = r_inst[INST_W-1:INST_W-OPCODE_LSB_OFFSET];
    assign imm        = r_inst[INST_W-IMM_BIT_OFFSET];

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (redirect),
        .i_load_pc (redirect_pc),
        .i_inc     (w_rsp_take),
        .o_pc      (w_pc)
    );

    // Fetch sequencer: one request in flight, drop flag marks a wrong-path response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FETCH;
            r_drop       <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_req_fire) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        r_drop <= 1'b0;
                        if (w_rsp_take) begin
                            r_inst       <= imem_rsp_data;
                            r_inst_pc    <= w_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= OUT;
                        end else begin
                            r_state <= FETCH;
                        end
                    end else if (redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                OUT: begin
                    // A same-cycle redirect flushes the presented instruction.
                    if (redirect || inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_state == WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic [4:0]  opcode;
    logic        imm;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W     (16),
        .INST_W   (32),
        .RESET_PC (16'h0000),
        .PC_INC   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .imm            (imm)
    );

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_deliv = 0;

    logic [15:0] q_req[$];
    exp_t        q_inst[$];

    // Reference model: next fetch address and the one outstanding memory access.
    logic [15:0] m_pc;
    bit          m_busy;
    bit          m_wrong;
    int          m_cnt;
    logic [15:0] m_raddr;

    int          p_rdy, p_irdy, p_redir, lat_max;
    bit          force_redir;
    logic [15:0] force_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_busy  = 0;
        m_wrong = 0;
        m_cnt   = 0;
        q_req.delete();
        q_inst.delete();
    endtask

    task automatic drive_idle();
        imem_req_ready = 0;
        imem_rsp_valid = 0;
        imem_rsp_data  = '0;
        redirect       = 0;
        redirect_pc    = '0;
        inst_ready     = 0;
    endtask

    // One cycle of stimulus plus the model's view of what the next edge does.
    task automatic step();
        logic [15:0] t;
        @(negedge clk);
        imem_rsp_valid = 0;
        if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rsp_valid = 1;
                imem_rsp_data  = mem_data(m_raddr);
            end
        end
        imem_req_ready = ($urandom_range(99) < p_rdy);
        inst_ready     = ($urandom_range(99) < p_irdy);
        t              = 16'($urandom) & 16'hFFFC;
        redirect       = force_redir || ($urandom_range(99) < p_redir);
        redirect_pc    = force_redir ? force_pc : t;
        force_redir    = 0;
        #1;
        if (imem_rsp_valid) begin
            m_busy = 0;
            if (!redirect && !m_wrong) begin
                q_inst.push_back('{m_pc, mem_data(m_pc)});
                m_pc = m_pc + 16'd4;
            end
            m_wrong = 0;
        end
        if (redirect) begin
            m_pc = redirect_pc;
            if (m_busy) m_wrong = 1;
            if (q_inst.size() > 0) void'(q_inst.pop_back());
        end
        if (imem_req_valid && imem_req_ready) begin
            q_req.push_back(m_pc);
            m_busy  = 1;
            m_cnt   = $urandom_range(lat_max, 1);
            m_raddr = imem_req_addr;
        end
    endtask

    // Monitor: compares every handshake and hold condition against the queues.
    bit          pv_inst_stall, pv_req_stall;
    logic [31:0] pv_inst;
    logic [15:0] pv_inst_pc, pv_req_addr;
    exp_t        mon_e;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            pv_inst_stall = 0;
            pv_req_stall  = 0;
        end else begin
            if (pv_inst_stall) begin
                check("inst_hold_valid", 32'(inst_valid), 32'd1);
                check("inst_hold_data", inst, pv_inst);
                check("inst_hold_pc", 32'(inst_pc), 32'(pv_inst_pc));
            end
            if (pv_req_stall && !redirect) begin
                check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                check("req_hold_addr", 32'(imem_req_addr), 32'(pv_req_addr));
            end
            check("one_outstanding", 32'(inst_valid & imem_req_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                if (q_req.size() == 0) check("req_unexpected", 32'd1, 32'd0);
                else check("req_addr", 32'(imem_req_addr), 32'(q_req.pop_front()));
            end
            if (inst_valid && inst_ready && !redirect) begin
                if (q_inst.size() == 0) begin
                    check("inst_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = q_inst.pop_front();
                    n_deliv++;
                    check("inst_data", inst, mon_e.data);
                    check("inst_pc", 32'(inst_pc), 32'(mon_e.pc));
                    check("opcode", 32'(opcode), 32'(mon_e.data[31:27]));
                    check("imm", 32'(imm), 32'(mon_e.data[26]));
                end
            end
            pv_inst_stall = inst_valid && !inst_ready && !redirect;
            pv_inst       = inst;
            pv_inst_pc    = inst_pc;
            pv_req_stall  = imem_req_valid && !imem_req_ready;
            pv_req_addr   = imem_req_addr;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_inst_pc"}, 32'(inst_pc), 32'd0);
        check({tag, "_req_addr"}, 32'(imem_req_addr), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Run until the model says the DUT is in the target state, then reset it asynchronously.
    task automatic reset_in_state(input bit want_out, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if (want_out) hit = (q_inst.size() > 0) && !(inst_valid && inst_ready);
            else          hit = m_busy && !imem_rsp_valid;
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
        @(posedge clk);
        #2;
        if (want_out) check({tag, "_pre_valid"}, 32'(inst_valid), 32'd1);
        else          check({tag, "_pre_idle"}, 32'(imem_req_valid | inst_valid), 32'd0);
        rst_n = 0;
        drive_idle();
        #1;
        check_reset_outputs(tag);
        model_reset();
        release_reset();
    endtask

    initial begin
        rst_n       = 0;
        force_redir = 0;
        force_pc    = '0;
        drive_idle();
        model_reset();
        #1;
        check_reset_outputs("reset");
        release_reset();

        // Always-ready memory and decode, 1-cycle latency: addresses 0, 4, 8, ...
        p_rdy = 100; p_irdy = 100; p_redir = 0; lat_max = 1;
        repeat (30) step();

        // Random back-pressure, latency and redirects.
        p_rdy = 60; p_irdy = 50; p_redir = 10; lat_max = 4;
        repeat (2000) step();

        // Sequential fetch across the top of the address space.
        p_rdy = 100; p_irdy = 100; p_redir = 0; lat_max = 1;
        force_redir = 1; force_pc = 16'hFFF8;
        repeat (40) step();

        // Asynchronous reset in the middle of WAIT and OUT.
        p_rdy = 80; p_irdy = 20; p_redir = 5; lat_max = 3;
        reset_in_state(1'b0, "rst_wait");
        repeat (50) step();
        reset_in_state(1'b1, "rst_out");
        repeat (200) step();

        // Drain with no redirects so the queues settle.
        p_rdy = 100; p_irdy = 100; p_redir = 0; lat_max = 2;
        repeat (30) step();
        @(negedge clk);
        check("drain_inst_queue", 32'(q_inst.size()), 32'(inst_valid));
        check("drain_req_queue", 32'(q_req.size()), 32'd0);
        check("progress", 32'(n_deliv > 100), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control unit in the 16-bit RISC pipeline.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready request channel, then captures the response.
- Presents the instruction to decode on a valid/ready output. Opcode [31:27] and immediate bit [26] are broken out for the control unit.
- Accepts a redirect (taken branch/call/ret target) from the branch unit and discards any wrong-path fetch.

Parameters:
- PC_W, 16, PC and address width.
- INST_W, 32, instruction width. Opcode is always INST_W-1 down to INST_W-5; the immediate bit is INST_W-6.
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_INC, 4, PC increment per sequential instruction (byte addressing).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  request valid to instruction memory.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  PC_W  request address (current PC).
- imem_rsp_valid  in  1  response data valid; one-cycle pulse, any latency of at least 1 cycle after acceptance.
- imem_rsp_data  in  INST_W  response instruction.
- redirect  in  1  one-cycle pulse: fetch from redirect_pc next.
- redirect_pc  in  PC_W  redirect target.
- inst_valid  out  1  instruction to decode is valid.
- inst_ready  in  1  decode accepts instruction.
- inst  out  INST_W  registered instruction.
- inst_pc  out  PC_W  PC of inst.
- opcode  out  5  inst[INST_W-1:INST_W-5].
- imm  out  1  inst[INST_W-6].

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RESET_PC, drop=0, inst=0, inst_pc=0, inst_valid=0. In reset, imem_req_valid=0.
- imem_req_valid = (state==FETCH) && !redirect. imem_req_addr = pc.
- FETCH:
  - On a request handshake (req_valid && req_ready): go to WAIT.
  - On redirect: pc<=redirect_pc and stay in FETCH; no request is issued that cycle.
- WAIT:
  - rsp_valid && !drop && !redirect: inst<=rsp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+PC_INC (modulo 2^PC_W, wraps silently), go to OUT.
  - rsp_valid && drop: discard the response, drop<=0, go to FETCH (pc already holds the target).
  - redirect with no rsp_valid: pc<=redirect_pc, drop<=1, stay in WAIT.
  - redirect in the same cycle as rsp_valid: discard the response, pc<=redirect_pc, drop<=0, go to FETCH.
- OUT:
  - Outputs are held stable while inst_valid && !inst_ready.
  - Handshake (valid && ready): inst_valid<=0, go to FETCH.
  - Redirect has priority over a handshake in the same cycle: inst_valid<=0, pc<=redirect_pc, go to FETCH. Decode must treat a same-cycle redirect as a flush of the presented instruction.
- Latency:
  - Response in cycle N gives inst_valid in cycle N+1.
  - Handshake in cycle M gives the next request in cycle M+1.
  - Best-case throughput is 1 instruction per 3 cycles with 1-cycle memory latency.
- At most one outstanding request at any time. A response arriving outside WAIT is a protocol error: ignore it and flag it with an assertion.
- Reset asserted mid-operation immediately returns the block to reset values. A pending response is not tracked; the memory must also be reset.
- opcode and imm are combinational slices of the registered inst.

Decomposition:
- Shared package risc_pkg:
  - fetch_state_t enum {FETCH, WAIT, OUT}.
  - OPCODE_W=5, OPCODE_LSB_OFFSET and IMM_BIT_OFFSET constants.
  - RESET_PC default.
  - Opcode localparams (NOP=5'b01101, B=5'b10010, CALL=5'b10011, RET=5'b10100), shared with the control unit.
- One sub-module: fetch_pc_reg, holding the PC register with priority next-PC select (redirect > increment > hold).
- FSM and output register stay in fetch_unit.

Test Plan:
- Reset, then memory always ready with 1-cycle latency returning 32'h0000_0001, 0x08000002, ... → request addresses 0x0000, 0x0004, 0x0008. inst_pc matches each address; the opcode of 0x08000002 is 5'b00001 and imm=0.
- Decode holds inst_ready=0 for 5 cycles in OUT → inst and inst_pc stable, no new request; one request follows the cycle after ready rises.
- Redirect to 0x0100 while in WAIT; a stale response arrives 3 cycles later → stale response discarded, inst_valid stays 0, next request address is 0x0100.
- Redirect to 0x0040 in the same cycle as rsp_valid, and separately in the same cycle as inst_ready in OUT → no instruction is delivered to decode; next request address is 0x0040.
- PC at 0xFFFC, sequential fetch → next address 0x0000 (wrap). imem_req_ready held low 4 cycles in FETCH → req_valid held with a stable address.
- rst_n asserted low in WAIT and in OUT → outputs go to reset values immediately (asynchronously). After release, the first request address is RESET_PC.
